// File: rtl/random_position_picker.sv
// Spawn-coordinate picker: pulls random words from the LFSR generator and maps them
// into the [X_MIN..X_MAX] x [Y_MIN..Y_MAX] rectangle by bounded rejection sampling.
module random_position_picker #(
    parameter int X_MIN     = 0,
    parameter int X_MAX     = 639,
    parameter int Y_MIN     = 160,
    parameter int Y_MAX     = 479,
    parameter int MAX_TRIES = 4
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        request,
    input  logic [15:0] randomLatch,
    output logic        storeValue,
    output logic        busy,
    output logic        valid,
    output logic [10:0] posX,
    output logic [10:0] posY,
    output logic        fallback
);

    // Smallest 2^k-1 covering the span, so a masked candidate is rejected less than half the time.
    function automatic int calc_mask(input int span);
        int m;
        m = 0;
        while (m < span) m = (m << 1) | 1;
        return m;
    endfunction

    localparam logic [10:0] SPAN_X = 11'(X_MAX - X_MIN);
    localparam logic [10:0] SPAN_Y = 11'(Y_MAX - Y_MIN);
    localparam logic [10:0] MASK_X = 11'(calc_mask(X_MAX - X_MIN));
    localparam logic [10:0] MASK_Y = 11'(calc_mask(Y_MAX - Y_MIN));
    localparam int          TW     = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TW-1:0] LAST_TRY = TW'(MAX_TRIES - 1);

    typedef enum logic [2:0] {
        IDLE, FETCH_X, CHECK_X, FETCH_Y, CHECK_Y, DONE
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] try_q, try_d;
    logic          fb_q, fb_d;
    logic [10:0]   off_x_q, off_x_d;
    logic [10:0]   pos_x_q, pos_x_d;
    logic [10:0]   pos_y_q, pos_y_d;
    logic          fallback_q, fallback_d;

    logic [10:0] cand_x, cand_y;
    logic        unused_bits;

    assign cand_x      = randomLatch[10:0] & MASK_X;
    assign cand_y      = randomLatch[10:0] & MASK_Y;
    assign unused_bits = ^randomLatch[15:11];

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the case infers a latch.
        state_d    = state_q;
        try_d      = try_q;
        fb_d       = fb_q;
        off_x_d    = off_x_q;
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        fallback_d = fallback_q;

        unique case (state_q)
            IDLE: begin
                if (request) begin
                    state_d = FETCH_X;
                    try_d   = '0;
                    fb_d    = 1'b0;
                end
            end
            FETCH_X: state_d = CHECK_X;
            CHECK_X: begin
                if (cand_x <= SPAN_X) begin
                    off_x_d = cand_x;
                    try_d   = '0;
                    state_d = FETCH_Y;
                end else if (try_q == LAST_TRY) begin
                    // Halving a masked value always lands inside the span.
                    off_x_d = cand_x >> 1;
                    fb_d    = 1'b1;
                    try_d   = '0;
                    state_d = FETCH_Y;
                end else begin
                    try_d   = try_q + TW'(1);
                    state_d = FETCH_X;
                end
            end
            FETCH_Y: state_d = CHECK_Y;
            CHECK_Y: begin
                if (cand_y <= SPAN_Y) begin
                    pos_x_d    = 11'(X_MIN) + off_x_q;
                    pos_y_d    = 11'(Y_MIN) + cand_y;
                    fallback_d = fb_q;
                    try_d      = '0;
                    state_d    = DONE;
                end else if (try_q == LAST_TRY) begin
                    pos_x_d    = 11'(X_MIN) + off_x_q;
                    pos_y_d    = 11'(Y_MIN) + (cand_y >> 1);
                    fb_d       = 1'b1;
                    fallback_d = 1'b1;
                    try_d      = '0;
                    state_d    = DONE;
                end else begin
                    try_d   = try_q + TW'(1);
                    state_d = FETCH_Y;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= IDLE;
            try_q      <= '0;
            fb_q       <= 1'b0;
            off_x_q    <= '0;
            pos_x_q    <= '0;
            pos_y_q    <= '0;
            fallback_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            try_q      <= try_d;
            fb_q       <= fb_d;
            off_x_q    <= off_x_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            fallback_q <= fallback_d;
        end
    end

    assign storeValue = (state_q == FETCH_X) || (state_q == FETCH_Y);
    assign busy       = (state_q != IDLE);
    assign valid      = (state_q == DONE);
    assign posX       = pos_x_q;
    assign posY       = pos_y_q;
    assign fallback   = fallback_q;

endmodule
